// File: rtl/uart_tx_fifo_ctrl.sv
// Byte FIFO feeding a UART sender: bytes queued from the CPU bus are launched
// one at a time with a single-cycle TX_EN pulse, waiting for the sender to finish each frame.
module uart_tx_fifo_ctrl #(
    parameter int DEPTH = 8,
    parameter int AW    = 3
) (
    input  logic          sysclk,
    input  logic          reset,
    input  logic          wr_en,
    input  logic [7:0]    wr_data,
    input  logic          clr_ovf,
    input  logic          TX_STATUS,
    output logic          TX_EN,
    output logic [7:0]    TX_DATA,
    output logic          fifo_full,
    output logic          fifo_empty,
    output logic [AW:0]   fifo_count,
    output logic          overflow,
    output logic          busy
);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_BUSY = 2'd1,
        WAIT_DONE = 2'd2
    } state_t;

    localparam logic [AW:0]   CNT_FULL = (AW+1)'(DEPTH);
    localparam logic [AW:0]   CNT_ZERO = (AW+1)'(0);
    localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
    localparam logic [AW-1:0] PTR_ONE  = (AW)'(1);

    state_t        state_r, state_next_s;
    logic [7:0]    mem_r [DEPTH];
    logic [AW-1:0] wp_r, rp_r;
    logic [AW:0]   count_r, count_next_s;
    logic          full_r, empty_r, tx_en_r, ovf_r, ovf_next_s, busy_r;
    logic [7:0]    tx_data_r;
    logic          pop_s, wr_accept_s, wr_drop_s;

    // A pop frees a slot on the same edge, so a write to a full FIFO is still taken then.
    always_comb begin
        pop_s       = (state_r == IDLE) && !empty_r && !TX_STATUS;
        wr_accept_s = wr_en && (!full_r || pop_s);
        wr_drop_s   = wr_en && full_r && !pop_s;
    end

    // Occupancy and sticky-overflow next values; a coincident drop beats the clear.
    always_comb begin
        count_next_s = count_r;
        case ({wr_accept_s, pop_s})
            2'b10:   count_next_s = count_r + CNT_ONE;
            2'b01:   count_next_s = count_r - CNT_ONE;
            default: count_next_s = count_r;
        endcase
        if (wr_drop_s) begin
            ovf_next_s = 1'b1;
        end else if (clr_ovf) begin
            ovf_next_s = 1'b0;
        end else begin
            ovf_next_s = ovf_r;
        end
    end

    // Launch sequencer next-state logic.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            IDLE: begin
                if (pop_s) state_next_s = WAIT_BUSY;
                else       state_next_s = IDLE;
            end
            WAIT_BUSY: begin
                if (TX_STATUS) state_next_s = WAIT_DONE;
                else           state_next_s = WAIT_BUSY;
            end
            WAIT_DONE: begin
                if (!TX_STATUS) state_next_s = IDLE;
                else            state_next_s = WAIT_DONE;
            end
            default: state_next_s = IDLE;
        endcase
    end

    // Control state, pointers, flags and registered outputs.
    always_ff @(posedge sysclk or posedge reset) begin
        if (reset) begin
            state_r   <= IDLE;
            wp_r      <= {AW{1'b0}};
            rp_r      <= {AW{1'b0}};
            count_r   <= CNT_ZERO;
            full_r    <= 1'b0;
            empty_r   <= 1'b1;
            tx_en_r   <= 1'b0;
            tx_data_r <= 8'h00;
            ovf_r     <= 1'b0;
            busy_r    <= 1'b0;
        end else begin
            state_r <= state_next_s;
            count_r <= count_next_s;
            full_r  <= (count_next_s == CNT_FULL);
            empty_r <= (count_next_s == CNT_ZERO);
            tx_en_r <= pop_s;
            ovf_r   <= ovf_next_s;
            busy_r  <= (state_next_s != IDLE);
            if (wr_accept_s) wp_r <= wp_r + PTR_ONE;
            if (pop_s) begin
                rp_r      <= rp_r + PTR_ONE;
                tx_data_r <= mem_r[rp_r];
            end
        end
    end

    // Storage is deliberately left out of reset; stale bytes are unreachable once pointers clear.
    always_ff @(posedge sysclk) begin
        if (wr_accept_s) mem_r[wp_r] <= wr_data;
    end

    assign TX_EN      = tx_en_r;
    assign TX_DATA    = tx_data_r;
    assign fifo_full  = full_r;
    assign fifo_empty = empty_r;
    assign fifo_count = count_r;
    assign overflow   = ovf_r;
    assign busy       = busy_r;

endmodule
